dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous data memory between the CPU datapath (port 0) and the program/debug loader (port 1). It sits between the CPU's memory-access signals and the data memory, serialises accesses with a req/gnt/rvalid handshake, and returns read data to the requester that issued the read. Only one transaction is outstanding at a time.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arb_pick.sv | 35 +++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants and helpers for the data memory arbiter
package dmem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_ACCESS = 2'd1;
    localparam arb_state_t ST_WAIT   = 2'd2;
    localparam arb_state_t ST_RESP   = 2'd3;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - two-input grant selector; DMEM_ARB_RR_EN selects round-robin ties
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       winner
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        any    = |req;
        winner = PORT_LDR;
        if (req == 2'b11) begin
            winner = other_port(last);
        end else if (req[0]) begin
            winner = PORT_CPU;
        end
    end
`else
    // Fixed priority: the last owner does not influence the choice.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        any    = |req;
        winner = PORT_LDR;
        if (req[0]) begin
            winner = PORT_CPU;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter for the single-port data memory (DMEM_ARB_RR_EN: round-robin)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_wen,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_wen,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p0_stall,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    arb_state_t        state;
    logic              owner;
    logic              lat_wen;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p1_rdata_q;
    logic              pick_any;
    logic              pick_winner;

    dmem_arb_pick u_pick (
        .req    ({p1_req, p0_req}),
        .last   (owner),
        .any    (pick_any),
        .winner (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= PORT_LDR;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            wait_cnt   <= '0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner     <= pick_winner;
                        lat_wen   <= pick_winner ? p1_wen   : p0_wen;
                        lat_addr  <= pick_winner ? p1_addr  : p0_addr;
                        lat_wdata <= pick_winner ? p1_wdata : p0_wdata;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    wait_cnt <= '0;
                    state    <= lat_wen ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    // Memory data is valid during the final wait cycle only.
                    if (wait_cnt == CNT_W'(RD_LAT - 1)) begin
                        if (owner == PORT_LDR) begin
                            p1_rdata_q <= mem_rdata;
                        end else begin
                            p0_rdata_q <= mem_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state == ST_ACCESS);
    assign mem_wen   = mem_en & lat_wen;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    assign p0_gnt    = mem_en & (owner == PORT_CPU);
    assign p1_gnt    = mem_en & (owner == PORT_LDR);
    assign p0_rvalid = (state == ST_RESP) & (owner == PORT_CPU);
    assign p1_rvalid = (state == ST_RESP) & (owner == PORT_LDR);
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

    // Stall drops only in the cycle the CPU's own transaction completes.
    assign p0_stall  = p0_req & ~(p0_gnt & lat_wen) & ~p0_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized check of dmem_arbiter (RD_LAT 1 and 3) against a transaction model
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_wen, p1_req, p1_wen;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;

    logic [6:0]    ctl_o  [2];
    logic [DW-1:0] rd0_o  [2];
    logic [DW-1:0] rd1_o  [2];
    logic [AW-1:0] addr_o [2];
    logic [DW-1:0] wd_o   [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hC0DE_0000 | (i * 17);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : 3;
        logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_stall;
        logic          mem_en, mem_wen;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata, mem_rdata, p0_rdata, p1_rdata;
        logic [DW-1:0] sram [32];
        logic [DW-1:0] pipe [L];

        dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .p0_req    (p0_req),
            .p0_wen    (p0_wen),
            .p0_addr   (p0_addr),
            .p0_wdata  (p0_wdata),
            .p1_req    (p1_req),
            .p1_wen    (p1_wen),
            .p1_addr   (p1_addr),
            .p1_wdata  (p1_wdata),
            .p0_gnt    (p0_gnt),
            .p1_gnt    (p1_gnt),
            .p0_rvalid (p0_rvalid),
            .p1_rvalid (p1_rvalid),
            .p0_rdata  (p0_rdata),
            .p1_rdata  (p1_rdata),
            .p0_stall  (p0_stall),
            .mem_en    (mem_en),
            .mem_wen   (mem_wen),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        initial for (int i = 0; i < 32; i++) sram[i] = init_word(i);

        // Synchronous SRAM with an L-stage read pipeline; junk when not reading.
        always @(posedge clk) begin
            if (mem_en && mem_wen) sram[mem_addr[4:0]] <= mem_wdata;
            pipe[0] <= (mem_en && !mem_wen) ? sram[mem_addr[4:0]] : 32'hBAD0_0BAD;
            for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
        end
        assign mem_rdata = pipe[L-1];

        assign ctl_o[k]  = {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_en, mem_wen, p0_stall};
        assign rd0_o[k]  = p0_rdata;
        assign rd1_o[k]  = p1_rdata;
        assign addr_o[k] = mem_addr;
        assign wd_o[k]   = mem_wdata;
    end

    // Transaction-level reference: one record per instance, events derived from start cycle.
    logic          mvalid = 1'b0;
    logic          m_act  [2];
    int            m_s    [2];
    logic          m_own  [2];
    logic          m_wen  [2];
    logic [4:0]    m_addr [2];
    logic [DW-1:0] m_wd   [2];
    logic [DW-1:0] m_exp  [2];
    logic          m_last [2];
    logic [DW-1:0] m_rd0  [2];
    logic [DW-1:0] m_rd1  [2];
    logic [DW-1:0] refm   [2][32];

    initial for (int k = 0; k < 2; k++) for (int i = 0; i < 32; i++) refm[k][i] = init_word(i);

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin : model
            int         lat;
            logic       g, rv;
            logic [6:0] e;
            lat = (k == 0) ? 1 : 3;
            if (mvalid) begin
                g  = m_act[k] && (cyc == m_s[k] + 1);
                rv = m_act[k] && !m_wen[k] && (cyc == m_s[k] + 2 + lat);
                e  = {g && !m_own[k], g && m_own[k], rv && !m_own[k], rv && m_own[k],
                      g, g && m_wen[k], p0_req && !(!m_own[k] && ((g && m_wen[k]) || rv))};
                chk($sformatf("ctl%0d", k), 64'(ctl_o[k]), 64'(e));
                chk($sformatf("p0_rdata%0d", k), 64'(rd0_o[k]), 64'(m_rd0[k]));
                chk($sformatf("p1_rdata%0d", k), 64'(rd1_o[k]), 64'(m_rd1[k]));
                if (g) chk($sformatf("mem_addr%0d", k), 64'(addr_o[k]), 64'(m_addr[k]));
                if (g && m_wen[k]) chk($sformatf("mem_wdata%0d", k), 64'(wd_o[k]), 64'(m_wd[k]));
            end
            if (reset) begin
                mvalid    = 1'b1;
                m_act[k]  = 1'b0;
                m_last[k] = 1'b1;
                m_rd0[k]  = '0;
                m_rd1[k]  = '0;
            end else if (mvalid && !m_act[k]) begin
                if (p0_req || p1_req) begin
                    if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
                        m_own[k] = !m_last[k];
`else
                        m_own[k] = 1'b0;
`endif
                    end else begin
                        m_own[k] = p1_req;
                    end
                    m_act[k]  = 1'b1;
                    m_s[k]    = cyc;
                    m_last[k] = m_own[k];
                    m_wen[k]  = m_own[k] ? p1_wen : p0_wen;
                    m_addr[k] = m_own[k] ? p1_addr[4:0] : p0_addr[4:0];
                    m_wd[k]   = m_own[k] ? p1_wdata : p0_wdata;
                    if (m_wen[k]) refm[k][m_addr[k]] = m_wd[k];
                    else          m_exp[k] = refm[k][m_addr[k]];
                end
            end else if (mvalid) begin
                if (!m_wen[k] && (cyc + 1 == m_s[k] + 2 + lat)) begin
                    if (m_own[k]) m_rd1[k] = m_exp[k];
                    else          m_rd0[k] = m_exp[k];
                end
                if (cyc + 1 == (m_wen[k] ? m_s[k] + 2 : m_s[k] + 3 + lat)) m_act[k] = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic port, input logic req, input logic wen,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port) begin
            p1_req = req; p1_wen = wen; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_wen = wen; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic issue(input logic port, input logic wen,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        set_req(port, 1'b1, wen, addr, wdata);
        step(1);
        set_req(port, 1'b0, 1'b0, '0, '0);
        step(8);
    endtask

    initial begin
        int n0, n1, t1, t2;
        logic [DW-1:0] d1, d2;
        reset = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 32'h3, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        step(2);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_ctl%0d", k), 64'(ctl_o[k] & 7'b1111110), 64'd0);
            chk($sformatf("reset_rdata%0d", k), 64'(rd0_o[k] | rd1_o[k]), 64'd0);
        end
        reset = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        step(8);

        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        issue(1'b1, 1'b0, 32'h10, '0);
        chk("p1_read_data", 64'(g_dut[0].p1_rdata), 64'hDEADBEEF);
        chk("p0_untouched", 64'(g_dut[0].p0_rdata), 64'h0);

        n0 = 0; n1 = 0;
        set_req(1'b0, 1'b1, 1'b0, 32'h4, '0);
        set_req(1'b1, 1'b1, 1'b0, 32'h5, '0);
        repeat (16) begin
            step(1);
            n0 += int'(g_dut[0].p0_gnt);
            n1 += int'(g_dut[0].p1_gnt);
        end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
`ifdef DMEM_ARB_RR_EN
        chk("conflict_p0_grants", 64'(n0), 64'd2);
        chk("conflict_p1_grants", 64'(n1), 64'd2);
`else
        chk("conflict_p0_grants", 64'(n0), 64'd4);
        chk("conflict_p1_grants", 64'(n1), 64'd0);
`endif
        step(8);

        set_req(1'b0, 1'b1, 1'b0, 32'h7, '0);
        step(1);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("abort_rvalid", 64'(g_dut[0].p0_rvalid), 64'd0);
        chk("abort_rdata", 64'(g_dut[0].p0_rdata), 64'd0);
        step(4);

        t1 = -1; t2 = -1; d1 = '0; d2 = '0;
        set_req(1'b0, 1'b1, 1'b0, 32'h1, '0);
        for (int t = 1; t <= 12; t++) begin
            step(1);
            if (t == 2) p0_addr = 32'h2;
            if (g_dut[1].p0_rvalid) begin
                if (t1 < 0) begin t1 = t; d1 = g_dut[1].p0_rdata; end
                else        begin t2 = t; d2 = g_dut[1].p0_rdata; end
            end
        end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        chk("lat3_rvalid1_cycle", 64'(t1), 64'd5);
        chk("lat3_rvalid2_cycle", 64'(t2), 64'd11);
        chk("lat3_data1", 64'(d1), 64'(init_word(1)));
        chk("lat3_data2", 64'(d2), 64'(init_word(2)));
        step(8);

        repeat (3000) begin
            reset = ($urandom_range(0, 199) == 0);
            set_req(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    AW'($urandom_range(0, 31)), $urandom);
            set_req(1'b1, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                    AW'($urandom_range(0, 31)), $urandom);
            step(1);
        end
        reset = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        step(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
